// File: rtl/median_pkg.sv
// Shared types and window slice constants for the median-filter datapath.
// Used by window_3x3_gen and the downstream sorter stage.
package median_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [2:0] win_row_t;

  // Column slots inside a packed row: left in the MSBs.
  localparam int SLOT_L = 2;
  localparam int SLOT_C = 1;
  localparam int SLOT_R = 0;

  localparam int L_LO = SLOT_L * PIX_W;
  localparam int C_LO = SLOT_C * PIX_W;
  localparam int R_LO = SLOT_R * PIX_W;

  function automatic pix_t row_left(input win_row_t w);
    return w[SLOT_L];
  endfunction

  function automatic pix_t row_centre(input win_row_t w);
    return w[SLOT_C];
  endfunction

  function automatic pix_t row_right(input win_row_t w);
    return w[SLOT_R];
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Single-port line buffer: shared read/write address, read returns old data.
// Read is combinational so the old word is usable in the write cycle.
module line_buf_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator with two line buffers.
// Optional LINE_CHECK_EN: sticky err_out on eol / line-length mismatch.
module window_3x3_gen #(
  parameter int IMG_WIDTH = 640,
  parameter int PIX_W     = median_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               sof,
  input  logic               eol,
  output logic [3*PIX_W-1:0] win_top,
  output logic [3*PIX_W-1:0] win_mid,
  output logic [3*PIX_W-1:0] win_bot,
  output logic               win_valid,
  output logic               err_out
);

  import median_pkg::SLOT_C;
  import median_pkg::SLOT_R;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL2 = CW'(2);

  typedef logic [3*PIX_W-1:0] row_t;

  logic [CW-1:0]    col_q;
  logic [CW-1:0]    cur_col;
  logic [1:0]       row_q;
  logic [1:0]       cur_row;
  logic             wrap;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  row_t             top_q;
  row_t             mid_q;
  row_t             bot_q;
  logic             valid_q;

  // Old centre/right move left/centre; the new pixel enters right.
  function automatic row_t shift_in(
    input row_t             w,
    input logic [PIX_W-1:0] p
  );
    return {w[SLOT_C*PIX_W +: PIX_W],
            w[SLOT_R*PIX_W +: PIX_W],
            p};
  endfunction

  // sof overrides the counters for the pixel it marks.
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign wrap = (cur_col == LAST);

  line_buf_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .we      (pix_valid),
    .addr    (cur_col),
    .wr_data (pix_in),
    .rd_data (lb1_rd)
  );

  line_buf_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .we      (pix_valid),
    .addr    (cur_col),
    .wr_data (lb1_rd),
    .rd_data (lb0_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_valid) begin
      if (wrap) begin
        col_q <= '0;
        row_q <= (cur_row == 2'd2) ? cur_row : cur_row + 2'd1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pix_valid && (cur_row == 2'd2) && (cur_col >= COL2);
      if (pix_valid) begin
        top_q <= shift_in(top_q, lb0_rd);
        mid_q <= shift_in(mid_q, lb1_rd);
        bot_q <= shift_in(bot_q, pix_in);
      end
    end
  end

  assign win_top   = top_q;
  assign win_mid   = mid_q;
  assign win_bot   = bot_q;
  assign win_valid = valid_q;

`ifdef LINE_CHECK_EN
  logic err_q;
  logic bad_len;

  // eol must coincide exactly with the column wrap.
  assign bad_len = pix_valid && (eol != wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bad_len) begin
      err_q <= 1'b1;
    end
  end

  assign err_out = err_q;
`else
  logic unused_eol;

  assign unused_eol = eol;
  assign err_out    = 1'b0;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen with a frame-array reference model.
// Stimulus: directed frames, stall, sof restart, async reset, eol error.
module tb_window_3x3_gen;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic        eol = 1'b0;
  logic [23:0] win_top;
  logic [23:0] win_mid;
  logic [23:0] win_bot;
  logic        win_valid;
  logic        err_out;

  window_3x3_gen #(
    .IMG_WIDTH (W),
    .PIX_W     (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .eol       (eol),
    .win_top   (win_top),
    .win_mid   (win_mid),
    .win_bot   (win_bot),
    .win_valid (win_valid),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;
  int pulses  = 0;

  // Reference model: whole frame stored by frame row/column.
  logic [7:0]  img [16][W];
  int          mr = 0;
  int          mc = 0;
  logic        nx_valid = 1'b0;
  logic [23:0] nx_top = '0;
  logic [23:0] nx_mid = '0;
  logic [23:0] nx_bot = '0;
  logic        have_win = 1'b0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mr       = 0;
    mc       = 0;
    nx_valid = 1'b0;
    have_win = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] p, input bit s,
                              input bit e);
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
`ifdef LINE_CHECK_EN
    if (e != (mc == W - 1)) exp_err = 1'b1;
`else
    if (e) exp_err = exp_err;
`endif
    if (mr >= 2 && mc >= 2) begin
      nx_valid = 1'b1;
      nx_top = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc]};
      nx_mid = {img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc]};
      nx_bot = {img[mr][mc-2], img[mr][mc-1], img[mr][mc]};
      have_win = 1'b1;
    end else begin
      nx_valid = 1'b0;
      have_win = 1'b0;
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      if (mr < 15) mr++;
    end
  endtask

  task automatic px(input logic [7:0] p, input bit s, input bit e);
    @(negedge clk);
    pix_in    = p;
    pix_valid = 1'b1;
    sof       = s;
    eol       = e;
    model_accept(p, s, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      sof       = 1'b0;
      eol       = 1'b0;
      pix_in    = 8'hee;
      nx_valid  = 1'b0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_win(input string name, input logic [23:0] t,
                         input logic [23:0] m, input logic [23:0] b);
    chk({name, "_top"}, 72'(win_top), 72'(t));
    chk({name, "_mid"}, 72'(win_mid), 72'(m));
    chk({name, "_bot"}, 72'(win_bot), 72'(b));
  endtask

  function automatic logic [7:0] pa(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  // Per-cycle comparison against the model.
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("win_valid", 72'(win_valid), 72'(nx_valid));
      chk("err_out", 72'(err_out), 72'(exp_err));
      if (nx_valid || (!pix_valid && have_win)) begin
        chk("model_top", 72'(win_top), 72'(nx_top));
        chk("model_mid", 72'(win_mid), 72'(nx_mid));
        chk("model_bot", 72'(win_bot), 72'(nx_bot));
      end
      if (win_valid) pulses++;
    end
  end

  initial begin
    #3;
    chk_win("rst", 24'h0, 24'h0, 24'h0);
    chk("rst_valid", 72'(win_valid), 72'd0);
    chk("rst_err", 72'(err_out), 72'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame.
    pulses = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        px(pa(r, c), r == 0 && c == 0, c == W - 1);
        if (r == 2 && c == 2) begin
          after_edge();
          chk("first_valid", 72'(win_valid), 72'd1);
          chk_win("first", 24'h000102, 24'h101112, 24'h202122);
        end
      end
    end
    after_edge();
    chk_win("last", 24'h111213, 24'h212223, 24'h313233);
    idle(2);
    chk("pulses_a", 72'(pulses), 72'd4);

    // Stall before pixel (2,3).
    pulses = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 3) idle(3);
        px(pa(r, c), r == 0 && c == 0, c == W - 1);
        if (r == 2 && c == 3) begin
          after_edge();
          chk_win("resume", 24'h010203, 24'h111213, 24'h212223);
        end
      end
    end
    idle(2);
    chk("pulses_stall", 72'(pulses), 72'd4);

    // sof re-asserted at (2,1).
    pulses = 0;
    for (int i = 0; i < 9; i++) px(pa(i / W, i % W), i == 0, i % W == W - 1);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        px(8'(100 + 16 * r + c), r == 0 && c == 0, c == W - 1);
        if (r == 2 && c == 2) begin
          after_edge();
          chk_win("sof_new", 24'h646566, 24'h747576, 24'h848586);
        end
      end
    end
    idle(2);
    chk("pulses_sof", 72'(pulses), 72'd4);

    // Async reset mid-line after windows have been produced.
    for (int i = 0; i < 15; i++) px(pa(i / W, i % W), i == 0, i % W == W - 1);
    after_edge();
    chk("pre_rst_valid", 72'(win_valid), 72'd1);
    @(negedge clk);
    pix_valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_win("async_rst", 24'h0, 24'h0, 24'h0);
    chk("async_rst_valid", 72'(win_valid), 72'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        px(pa(r, c), r == 0 && c == 0, c == W - 1);
        if (r == 2 && c == 2) begin
          after_edge();
          chk_win("post_rst", 24'h000102, 24'h101112, 24'h202122);
        end
      end
    end
    idle(2);
    chk("pulses_rst", 72'(pulses), 72'd4);

    // Random 6-line frame checked by the model.
    pulses = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < W; c++)
        px(8'($urandom_range(0, 255)), r == 0 && c == 0, c == W - 1);
    idle(2);
    chk("pulses_rand", 72'(pulses), 72'd8);

    // Early eol on row 1.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) begin
        px(pa(r, c), r == 0 && c == 0, (r == 0) ? (c == W - 1) : (c == 2));
        if (r == 1 && c == 2) begin
          after_edge();
`ifdef LINE_CHECK_EN
          chk("err_set", 72'(err_out), 72'd1);
`else
          chk("err_tied", 72'(err_out), 72'd0);
`endif
        end
      end
    end
    idle(4);
`ifdef LINE_CHECK_EN
    chk("err_sticky", 72'(err_out), 72'd1);
`else
    chk("err_tied_end", 72'(err_out), 72'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
